// File: rtl/valu_pkg.sv
// Shared types and constants for the vALU writeback arbiter.
package valu_pkg;

  localparam int DATA_WIDTH = 64;
  localparam int ADDR_WIDTH = 32;

  localparam logic SRC_A = 1'b0;
  localparam logic SRC_B = 1'b1;

  // One pending VRF write: result data, destination and the three passthrough flags.
  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic [ADDR_WIDTH-1:0] addr;
    logic                  w_reg;
    logic                  sca;
    logic                  mask;
  } wb_entry_t;

  localparam int ENTRY_W = $bits(wb_entry_t);

endpackage

// File: rtl/valu_wb_arbiter_if.sv
// Bus bundle for the writeback arbiter: two unstallable result sources, their
// credit/overflow feedback, and the VRF write port.
//
// Handshake: a_valid/b_valid have no ready; every asserted cycle is a push that
// is either stored or dropped (dropping sets the sticky ovf flag). On the write
// port a transfer happens on a clock edge where wr_valid && wr_ready; while
// wr_valid is high and wr_ready is low, wr_valid and every wr_* field hold.
//
// master = the sources plus the VRF (drives results and wr_ready);
// slave  = the arbiter.
interface valu_wb_arbiter_if;

  logic                             a_valid;
  logic [valu_pkg::DATA_WIDTH-1:0]  a_vec;
  logic [valu_pkg::ADDR_WIDTH-1:0]  a_addr;
  logic                             a_w_reg;
  logic                             a_sca;
  logic                             a_mask;

  logic                             b_valid;
  logic [valu_pkg::DATA_WIDTH-1:0]  b_vec;
  logic [valu_pkg::ADDR_WIDTH-1:0]  b_addr;
  logic                             b_w_reg;
  logic                             b_sca;
  logic                             b_mask;

  logic                             a_afull;
  logic                             b_afull;
  logic                             a_ovf;
  logic                             b_ovf;

  logic                             wr_valid;
  logic                             wr_ready;
  logic [valu_pkg::DATA_WIDTH-1:0]  wr_data;
  logic [valu_pkg::ADDR_WIDTH-1:0]  wr_addr;
  logic                             wr_w_reg;
  logic                             wr_sca;
  logic                             wr_mask;
  logic                             wr_src;

  modport master (
    output a_valid, a_vec, a_addr, a_w_reg, a_sca, a_mask,
    output b_valid, b_vec, b_addr, b_w_reg, b_sca, b_mask,
    output wr_ready,
    input  a_afull, b_afull, a_ovf, b_ovf,
    input  wr_valid, wr_data, wr_addr, wr_w_reg, wr_sca, wr_mask, wr_src
  );

  modport slave (
    input  a_valid, a_vec, a_addr, a_w_reg, a_sca, a_mask,
    input  b_valid, b_vec, b_addr, b_w_reg, b_sca, b_mask,
    input  wr_ready,
    output a_afull, b_afull, a_ovf, b_ovf,
    output wr_valid, wr_data, wr_addr, wr_w_reg, wr_sca, wr_mask, wr_src
  );

endinterface

// File: rtl/valu_wb_fifo.sv
// Synchronous FIFO of writeback entries. A push while full is taken only if a
// pop happens in the same cycle; otherwise it is ignored (the caller flags it).
module valu_wb_fifo
  import valu_pkg::*;
#(
  parameter  int DEPTH = 16,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = PW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  wb_entry_t     push_data,
  input  logic          pop,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count,
  output wb_entry_t     head
);

  wb_entry_t     mem_q [DEPTH];
  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign head  = mem_q[rptr_q];

  // Qualify push/pop and compute next pointers and occupancy.
  always_comb begin
    do_pop  = pop && !empty;
    do_push = push && (!full || do_pop);
    wptr_d  = do_push ? wptr_q + PW'(1) : wptr_q;
    rptr_d  = do_pop  ? rptr_q + PW'(1) : rptr_q;
    count_d = count_q;
    if (do_push && !do_pop) begin
      count_d = count_q + CW'(1);
    end else if (!do_push && do_pop) begin
      count_d = count_q - CW'(1);
    end
  end

  // Pointer and count registers; reset empties the FIFO regardless of push/pop.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Storage array; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wptr_q] <= push_data;
    end
  end

endmodule

// File: rtl/valu_wb_arbiter.sv
// Writeback arbiter: buffers two unstallable vALU result streams and merges
// them round-robin into a single registered VRF write request.
module valu_wb_arbiter
  import valu_pkg::*;
#(
  parameter int FIFO_DEPTH   = 16,
  parameter int AFULL_MARGIN = 7
) (
  input  logic               clk,
  input  logic               rst,
  valu_wb_arbiter_if.slave   bus
);

  localparam int            CW       = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] AFULL_TH = CW'(FIFO_DEPTH - AFULL_MARGIN);

  wb_entry_t     a_in, b_in, a_head, b_head;
  logic          a_full, a_empty, b_full, b_empty;
  logic [CW-1:0] a_count, b_count;
  logic          a_pop, b_pop, load, grant;

  // rr_q holds the source preferred when both FIFOs have an entry.
  logic          rr_q, rr_d;
  logic          wr_valid_q, wr_valid_d;
  wb_entry_t     wr_q, wr_d;
  logic          wr_src_q, wr_src_d;
  logic          a_ovf_q, a_ovf_d;
  logic          b_ovf_q, b_ovf_d;

  // Pack incoming source fields into entries.
  always_comb begin
    a_in = '{data: bus.a_vec, addr: bus.a_addr, w_reg: bus.a_w_reg, sca: bus.a_sca, mask: bus.a_mask};
    b_in = '{data: bus.b_vec, addr: bus.b_addr, w_reg: bus.b_w_reg, sca: bus.b_sca, mask: bus.b_mask};
  end

  valu_wb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo_a (
    .clk(clk), .rst(rst), .push(bus.a_valid), .push_data(a_in), .pop(a_pop),
    .full(a_full), .empty(a_empty), .count(a_count), .head(a_head)
  );

  valu_wb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo_b (
    .clk(clk), .rst(rst), .push(bus.b_valid), .push_data(b_in), .pop(b_pop),
    .full(b_full), .empty(b_empty), .count(b_count), .head(b_head)
  );

  // Arbitration, output-register load and sticky overflow detection.
  always_comb begin
    load = (!wr_valid_q || bus.wr_ready) && (!a_empty || !b_empty);
    if (!a_empty && !b_empty) begin
      grant = rr_q;
    end else if (!a_empty) begin
      grant = SRC_A;
    end else begin
      grant = SRC_B;
    end
    a_pop = load && (grant == SRC_A);
    b_pop = load && (grant == SRC_B);

    rr_d       = load ? ~grant : rr_q;
    wr_valid_d = wr_valid_q;
    wr_d       = wr_q;
    wr_src_d   = wr_src_q;
    if (load) begin
      wr_valid_d = 1'b1;
      wr_d       = (grant == SRC_B) ? b_head : a_head;
      wr_src_d   = grant;
    end else if (bus.wr_ready) begin
      wr_valid_d = 1'b0;
    end

    a_ovf_d = a_ovf_q || (bus.a_valid && a_full && !a_pop);
    b_ovf_d = b_ovf_q || (bus.b_valid && b_full && !b_pop);
  end

  // State registers; reset clears the output request and flags, A preferred.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_q       <= SRC_A;
      wr_valid_q <= 1'b0;
      wr_q       <= '0;
      wr_src_q   <= 1'b0;
      a_ovf_q    <= 1'b0;
      b_ovf_q    <= 1'b0;
    end else begin
      rr_q       <= rr_d;
      wr_valid_q <= wr_valid_d;
      wr_q       <= wr_d;
      wr_src_q   <= wr_src_d;
      a_ovf_q    <= a_ovf_d;
      b_ovf_q    <= b_ovf_d;
    end
  end

  assign bus.a_afull  = (a_count >= AFULL_TH);
  assign bus.b_afull  = (b_count >= AFULL_TH);
  assign bus.a_ovf    = a_ovf_q;
  assign bus.b_ovf    = b_ovf_q;
  assign bus.wr_valid = wr_valid_q;
  assign bus.wr_data  = wr_q.data;
  assign bus.wr_addr  = wr_q.addr;
  assign bus.wr_w_reg = wr_q.w_reg;
  assign bus.wr_sca   = wr_q.sca;
  assign bus.wr_mask  = wr_q.mask;
  assign bus.wr_src   = wr_src_q;

endmodule

// File: tb/tb_valu_wb_arbiter.sv
// Directed bench for valu_wb_arbiter with per-source expected queues.
module tb_valu_wb_arbiter;
  import valu_pkg::*;

  localparam int DEPTH = 16;
  localparam int EW    = ENTRY_W;

  logic clk = 1'b0;
  logic rst = 1'b1;

  valu_wb_arbiter_if bus();

  valu_wb_arbiter #(.FIFO_DEPTH(DEPTH), .AFULL_MARGIN(7)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  // Clock
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [EW-1:0] exp_a_q[$];
  logic [EW-1:0] exp_b_q[$];
  logic          src_q[$];

  // Occupancy model used when only source A is active.
  int   m_cnt;
  logic m_wv;
  logic m_ovf;

  function automatic logic [EW-1:0] mk(input logic [63:0] d, input logic [31:0] a, input logic [2:0] f);
    return {d, a, f};
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_a(input logic v, input logic [EW-1:0] e);
    bus.a_valid = v;
    {bus.a_vec, bus.a_addr, bus.a_w_reg, bus.a_sca, bus.a_mask} = e;
  endtask

  task automatic drive_b(input logic v, input logic [EW-1:0] e);
    bus.b_valid = v;
    {bus.b_vec, bus.b_addr, bus.b_w_reg, bus.b_sca, bus.b_mask} = e;
  endtask

  // Check any transfer happening at the coming edge, then advance one cycle.
  task automatic step();
    logic [EW-1:0] got;
    logic [EW-1:0] want;
    if (bus.wr_valid === 1'b1 && bus.wr_ready === 1'b1) begin
      got = {bus.wr_data, bus.wr_addr, bus.wr_w_reg, bus.wr_sca, bus.wr_mask};
      src_q.push_back(bus.wr_src);
      if (bus.wr_src === SRC_B) begin
        if (exp_b_q.size() == 0) chk("b_unexpected", 1, 0);
        else begin
          want = exp_b_q.pop_front();
          chk("b_entry", got, want);
        end
      end else begin
        if (exp_a_q.size() == 0) chk("a_unexpected", 1, 0);
        else begin
          want = exp_a_q.pop_front();
          chk("a_entry", got, want);
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive_a(1'b0, '0);
    drive_b(1'b0, '0);
    bus.wr_ready = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_a_q.delete();
    exp_b_q.delete();
    src_q.delete();
    m_cnt = 0;
    m_wv  = 1'b0;
    m_ovf = 1'b0;
  endtask

  task automatic drain(input string tag, input int max);
    int n;
    n = 0;
    bus.wr_ready = 1'b1;
    drive_a(1'b0, '0);
    drive_b(1'b0, '0);
    while ((exp_a_q.size() != 0 || exp_b_q.size() != 0 || bus.wr_valid === 1'b1) && n < max) begin
      step();
      n++;
    end
    chk({tag, "_left"}, exp_a_q.size() + exp_b_q.size(), 0);
    chk({tag, "_valid_low"}, bus.wr_valid, 0);
  endtask

  // One cycle of an A-only push, tracking expected acceptance and overflow.
  task automatic a_only_cycle(input logic [EW-1:0] e);
    logic pop;
    logic acc;
    pop = (!m_wv || (bus.wr_ready === 1'b1)) && (m_cnt != 0);
    acc = (m_cnt < DEPTH) || pop;
    drive_a(1'b1, e);
    if (acc) exp_a_q.push_back(e);
    else m_ovf = 1'b1;
    m_cnt = m_cnt + (acc ? 1 : 0) - (pop ? 1 : 0);
    if (pop) m_wv = 1'b1;
    else if (bus.wr_ready === 1'b1) m_wv = 1'b0;
    step();
    drive_a(1'b0, '0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [EW-1:0] ea;
    logic [EW-1:0] eb;
    int n;
    int cyc;

    bus.wr_ready = 1'b0;
    drive_a(1'b0, '0);
    drive_b(1'b0, '0);

    // Reset state
    do_reset();
    chk("rst_wr_valid", bus.wr_valid, 0);
    chk("rst_wr_data", bus.wr_data, 0);
    chk("rst_afull", {bus.a_afull, bus.b_afull}, 0);
    chk("rst_ovf", {bus.a_ovf, bus.b_ovf}, 0);

    // Single A push: wr_valid appears two edges later
    bus.wr_ready = 1'b1;
    ea = mk(64'h00FF_00FF_00FF_00FF, 32'h40, 3'b000);
    drive_a(1'b1, ea);
    exp_a_q.push_back(ea);
    step();
    drive_a(1'b0, '0);
    chk("t1_valid_early", bus.wr_valid, 0);
    step();
    chk("t1_valid", bus.wr_valid, 1);
    chk("t1_data", bus.wr_data, 64'h00FF_00FF_00FF_00FF);
    chk("t1_addr", bus.wr_addr, 32'h40);
    chk("t1_src", bus.wr_src, 0);
    step();
    chk("t1_valid_fall", bus.wr_valid, 0);
    drain("t1_drain", 10);

    // Both sources push every cycle for 8 cycles: strict alternation
    do_reset();
    bus.wr_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      ea = mk({32'hA000_0000, 32'(i)}, 32'h1000 + 32'(i), 3'(i));
      eb = mk({32'hB000_0000, 32'(i)}, 32'h1800 + 32'(i), 3'(7 - i));
      drive_a(1'b1, ea);
      drive_b(1'b1, eb);
      exp_a_q.push_back(ea);
      exp_b_q.push_back(eb);
      step();
    end
    drain("t2_drain", 40);
    chk("t2_count", src_q.size(), 16);
    for (int i = 0; i < 16 && i < src_q.size(); i++) begin
      chk("t2_alternate", src_q[i], i % 2);
    end

    // Backpressure: request holds for 5 cycles, then B follows A
    do_reset();
    bus.wr_ready = 1'b0;
    ea = mk(64'h1111_2222_3333_4444, 32'h500, 3'b001);
    eb = mk(64'h5555_6666_7777_8888, 32'h600, 3'b110);
    drive_a(1'b1, ea);
    drive_b(1'b1, eb);
    exp_a_q.push_back(ea);
    exp_b_q.push_back(eb);
    step();
    drive_a(1'b0, '0);
    drive_b(1'b0, '0);
    step();
    for (int i = 0; i < 5; i++) begin
      chk("t3_hold_valid", bus.wr_valid, 1);
      chk("t3_hold_entry", {bus.wr_data, bus.wr_addr, bus.wr_w_reg, bus.wr_sca, bus.wr_mask}, ea);
      chk("t3_hold_src", bus.wr_src, 0);
      step();
    end
    bus.wr_ready = 1'b1;
    step();
    chk("t3_next_valid", bus.wr_valid, 1);
    chk("t3_next_src", bus.wr_src, 1);
    chk("t3_next_entry", {bus.wr_data, bus.wr_addr, bus.wr_w_reg, bus.wr_sca, bus.wr_mask}, eb);
    drain("t3_drain", 10);

    // Fill A with the write port stalled: afull threshold, overflow, push+pop when full
    do_reset();
    bus.wr_ready = 1'b0;
    for (int i = 0; i < 18; i++) begin
      a_only_cycle(mk({32'hC0DE_0000, 32'(i)}, 32'h2000 + 32'(i), 3'b101));
      chk("t4_afull", bus.a_afull, (m_cnt >= 9) ? 1 : 0);
      chk("t4_ovf", bus.a_ovf, m_ovf);
    end
    chk("t4_ovf_set", bus.a_ovf, 1);
    chk("t4_b_ovf", bus.b_ovf, 0);
    bus.wr_ready = 1'b1;
    a_only_cycle(mk(64'hF00D_F00D_F00D_F00D, 32'h2FFF, 3'b011));
    bus.wr_ready = 1'b0;
    chk("t4_full_pushpop_cnt", m_cnt, 16);
    chk("t4_afull_kept", bus.a_afull, 1);
    drain("t4_drain", 60);
    chk("t4_afull_clear", bus.a_afull, 0);
    chk("t4_ovf_sticky", bus.a_ovf, 1);

    // Pointer wrap: 40 A entries under credit flow, ready toggling
    do_reset();
    bus.wr_ready = 1'b1;
    n = 0;
    cyc = 0;
    while (n < 40 && cyc < 400) begin
      if (bus.a_afull !== 1'b1) begin
        ea = mk({32'h5A5A_0000, 32'(n)}, 32'h3000 + 32'(n), n[2:0]);
        drive_a(1'b1, ea);
        exp_a_q.push_back(ea);
        n++;
      end else begin
        drive_a(1'b0, '0);
      end
      step();
      bus.wr_ready = ~bus.wr_ready;
      cyc++;
    end
    drive_a(1'b0, '0);
    chk("t5_pushed", n, 40);
    drain("t5_drain", 100);
    chk("t5_no_ovf", bus.a_ovf, 0);

    // Reset with entries queued and a request pending
    do_reset();
    bus.wr_ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      a_only_cycle(mk({32'hDEAD_0000, 32'(i)}, 32'h4000 + 32'(i), 3'b010));
    end
    chk("t6_pre_valid", bus.wr_valid, 1);
    chk("t6_pre_afull", bus.a_afull, 1);
    chk("t6_pre_ovf", bus.a_ovf, 1);
    rst = 1'b1;
    bus.wr_ready = 1'b1;
    drive_a(1'b1, mk(64'hBAD0_BAD0_BAD0_BAD0, 32'h4FFF, 3'b111));
    @(posedge clk); #1;
    rst = 1'b0;
    drive_a(1'b0, '0);
    exp_a_q.delete();
    exp_b_q.delete();
    chk("t6_valid", bus.wr_valid, 0);
    chk("t6_afull", bus.a_afull, 0);
    chk("t6_ovf", bus.a_ovf, 0);
    for (int i = 0; i < 6; i++) begin
      step();
      chk("t6_no_stale", bus.wr_valid, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
